// File: rtl/intt_scaler.sv
// Final INTT stage: multiplies each butterfly output by N^-1 mod Q and
// streams the four scaled coefficients of a beat out one at a time.
module intt_scaler #(
    parameter int unsigned Q     = 998244353,
    parameter int unsigned N_INV = 998000641,
    parameter int unsigned LOG_N = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [29:0]      r1,
    input  logic [29:0]      r2,
    input  logic [29:0]      r3,
    input  logic [29:0]      r4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [29:0]      out_data,
    output logic [LOG_N-1:0] out_index,
    output logic             out_last
);

    // state | meaning
    // IDLE  | waiting for a beat; in_ready high
    // MUL   | products ri*N_INV being registered
    // RED   | products reduced mod Q
    // OUT   | four results streamed out, one per handshake
    typedef enum logic [1:0] {IDLE, MUL, RED, OUT} state_e;

    localparam logic [59:0] Q_W   = 60'(Q);
    localparam logic [59:0] NINV_W = 60'(N_INV);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [LOG_N-1:0] idx_q, idx_d;

    logic [29:0] coef_q [4];
    logic [59:0] prod_q [4];
    logic [29:0] res_q  [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
        end
    end

    // Datapath registers carry no reset: they are only observed through out_data,
    // which is gated by out_valid.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            coef_q[0] <= r1;
            coef_q[1] <= r2;
            coef_q[2] <= r3;
            coef_q[3] <= r4;
        end
        if (state_q == MUL) begin
            for (int i = 0; i < 4; i++) begin
                prod_q[i] <= 60'(coef_q[i]) * NINV_W;
            end
        end
        if (state_q == RED) begin
            for (int i = 0; i < 4; i++) begin
                res_q[i] <= 30'(prod_q[i] % Q_W);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_d = MUL;
                end
            end
            MUL: state_d = RED;
            RED: state_d = OUT;
            OUT: begin
                out_valid = !rst;
                if (out_ready) begin
                    sel_d = sel_q + 2'd1;
                    idx_d = idx_q + LOG_N'(1);
                    if (sel_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data  = out_valid ? res_q[sel_q] : 30'd0;
    assign out_index = idx_q;
    assign out_last  = out_valid && (idx_q == {LOG_N{1'b1}});

endmodule

// File: tb/tb_intt_scaler.sv
// Bench for intt_scaler: scoreboard of expected coefficients checked on every
// output handshake, plus per-scenario timing, stall and reset checks.
module tb_intt_scaler;

    localparam longint unsigned QM = 998244353;
    localparam longint unsigned NI = 998000641;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] r1, r2, r3, r4;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [11:0] out_index;
    logic        out_last;

    intt_scaler #(.Q(998244353), .N_INV(998000641), .LOG_N(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3),
        .r4        (r4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] data;
        logic [11:0] idx;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          last_cnt = 0;
    logic [11:0] tb_idx = '0;

    function automatic logic [29:0] ref_mod(input logic [29:0] r);
        longint unsigned p;
        p = 64'(r) * NI;
        return 30'(p % QM);
    endfunction

    function automatic void push_exp(input logic [29:0] d);
        exp_t e;
        e.data = d;
        e.idx  = tb_idx;
        e.last = (tb_idx == 12'hFFF);
        sb.push_back(e);
        tb_idx = tb_idx + 12'd1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (out_last) last_cnt++;
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got data=%0d idx=%0d, required no output", out_data, out_index);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_index !== e.idx || out_last !== e.last)
                    $display("FAIL sb_out: got data=%0d idx=%0d last=%0b, required data=%0d idx=%0d last=%0b",
                             out_data, out_index, out_last, e.data, e.idx, e.last);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [29:0] a, b, c, d, input logic [29:0] ea, eb, ec, ed);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL send_ready: in_ready=%0b, required 1 within 50 cycles", in_ready);
            return;
        end
        r1 = a; r2 = b; r3 = c; r4 = d;
        in_valid = 1'b1;
        push_exp(ea); push_exp(eb); push_exp(ec); push_exp(ed);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [29:0] a, b, c, d;
        a = 30'($urandom()); b = 30'($urandom()); c = 30'($urandom()); d = 30'($urandom());
        send(a, b, c, d, ref_mod(a), ref_mod(b), ref_mod(c), ref_mod(d));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            total_cnt++;
            $display("FAIL drain_timeout: %0d outputs pending, in_ready=%0b, required 0 pending and in_ready 1",
                     sb.size(), in_ready);
        end
    endtask

    task automatic wait_valid(output int ok);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        ok = out_valid ? 1 : 0;
        if (!out_valid) begin
            total_cnt++;
            $display("FAIL wait_valid: out_valid=%0b, required 1 within 20 cycles", out_valid);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        r1 = 30'd5; r2 = 30'd6; r3 = 30'd7; r4 = 30'd8;
        tick(); tick(); tick();
        total_cnt++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 30'd0) $display("FAIL rst_outputs: valid=%0b last=%0b data=%0d, required 0 0 0", out_valid, out_last, out_data);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b, required 0", in_ready);
        else pass_cnt++;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_index !== 12'd0) $display("FAIL rst_release: in_ready=%0b idx=%0d, required 1 0", in_ready, out_index);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL rst_no_output: out_valid high %0d cycles, required 0", bad);
        else pass_cnt++;
        tb_idx = '0;
    endtask

    task automatic test_basic();
        int lat = 1;
        send(30'd1, 30'd4096, 30'd0, 30'd8192, 30'd998000641, 30'd1, 30'd0, 30'd2);
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        total_cnt++;
        if (lat != 3) $display("FAIL basic_latency: first out_valid in cycle %0d after accept, required 3", lat);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_extremes();
        logic [29:0] c, d;
        c = 30'($urandom()); d = 30'h3FFFFFFF - 30'($urandom_range(0, 1000));
        send(30'd998244352, 30'h3FFFFFFF, c, d, 30'd243712, ref_mod(30'h3FFFFFFF), ref_mod(c), ref_mod(d));
        drain();
        c = 30'd998244353; d = 30'd998244354;
        send(c, d, 30'h3FFFFFFE, 30'd998244351, 30'd0, 30'd998000641, ref_mod(30'h3FFFFFFE), ref_mod(30'd998244351));
        drain();
    endtask

    task automatic test_stall();
        logic [29:0] a, b;
        logic [11:0] base;
        int ok;
        a = 30'($urandom()); b = 30'($urandom());
        base = tb_idx;
        send(a, b, 30'd123, 30'd456, ref_mod(a), ref_mod(b), ref_mod(30'd123), ref_mod(30'd456));
        wait_valid(ok);
        if (ok == 1) begin
            tick();
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                total_cnt++;
                if (out_valid !== 1'b1 || out_data !== ref_mod(b) || out_index !== base + 12'd1 || in_ready !== 1'b0)
                    $display("FAIL stall_hold: cyc %0d valid=%0b data=%0d idx=%0d in_ready=%0b, required 1 %0d %0d 0",
                             k, out_valid, out_data, out_index, in_ready, ref_mod(b), base + 12'd1);
                else
                    pass_cnt++;
                tick();
            end
        end
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_ignore();
        logic [29:0] a, b, c, d;
        int n = 0;
        a = 30'($urandom()); b = 30'($urandom()); c = 30'($urandom()); d = 30'($urandom());
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        r1 = a; r2 = b; r3 = c; r4 = d;
        in_valid = 1'b1;
        push_exp(ref_mod(a)); push_exp(ref_mod(b)); push_exp(ref_mod(c)); push_exp(ref_mod(d));
        tick();
        for (int k = 0; k < 5; k++) begin
            r1 = 30'($urandom()); r2 = 30'($urandom()); r3 = 30'($urandom()); r4 = 30'($urandom());
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL ignore_in_ready: cyc %0d got %0b, required 0", k, in_ready);
            else pass_cnt++;
            tick();
        end
        in_valid = 1'b0;
        drain();
        for (int k = 0; k < 8; k++) tick();
        total_cnt++;
        if (sb.size() != 0 || out_valid !== 1'b0) $display("FAIL ignore_extra: pending=%0d valid=%0b, required 0 0", sb.size(), out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int ok;
        int bad = 0;
        send_rand();
        wait_valid(ok);
        if (ok == 1) begin
            tick();
            tick();
        end
        rst = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL midrst_during: in_ready=%0b valid=%0b, required 0 0", in_ready, out_valid);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        #1;
        sb.delete();
        tb_idx = '0;
        total_cnt++;
        if (out_valid !== 1'b0 || out_index !== 12'd0 || in_ready !== 1'b1 || out_data !== 30'd0)
            $display("FAIL midrst_after: valid=%0b idx=%0d in_ready=%0b data=%0d, required 0 0 1 0",
                     out_valid, out_index, in_ready, out_data);
        else
            pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL midrst_partial: out_valid high %0d cycles, required 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        time t0 = 0, t1 = 0;
        last_cnt = 0;
        for (int b = 0; b < 1024; b++) begin
            send_rand();
            if (b == 0) t0 = $time;
            if (b == 1023) t1 = $time;
        end
        drain();
        total_cnt++;
        if (t1 - t0 != 1023 * 70) $display("FAIL b2b_rate: 1024 beats took %0t, required %0t", t1 - t0, 1023 * 70);
        else pass_cnt++;
        total_cnt++;
        if (last_cnt != 1) $display("FAIL b2b_last_count: got %0d, required 1", last_cnt);
        else pass_cnt++;
        total_cnt++;
        if (tb_idx !== 12'd0) $display("FAIL b2b_wrap: model index %0d, required 0", tb_idx);
        else pass_cnt++;
        send_rand();
        drain();
        total_cnt++;
        if (last_cnt != 1) $display("FAIL b2b_next_frame_last: got %0d, required 1", last_cnt);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        r1 = '0; r2 = '0; r3 = '0; r4 = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_stall();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/intt_scaler.md
INTT_SCALER -- requirements
Module: intt_scaler

Interface
REQ-001 SHALL have parameter Q, default 998244353, 30-bit prime modulus.
REQ-002 SHALL have parameter N_INV, default 998000641, 4096^-1 mod Q.
REQ-003 SHALL have parameter LOG_N, default 12, log2 of coefficients per frame.
REQ-004 SHALL have port clk  input  1  clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 SHALL have ports r1, r2, r3, r4  input  30 each  coefficients from intt_core butterflies, r1 first.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-011 SHALL have port out_data  output  30  scaled coefficient.
REQ-012 SHALL have port out_index  output  LOG_N  frame position of out_data.
REQ-013 SHALL have port out_last  output  1  high with out_valid on the final coefficient of a frame.

Function
REQ-014 SHALL run FSM states IDLE, MUL, RED, OUT; in_ready = 1 only in IDLE.
REQ-015 SHALL, on accept in IDLE, capture r1..r4 and go to MUL next cycle.
REQ-016 SHALL in MUL register the four 60-bit products ri*N_INV, then go to RED.
REQ-017 SHALL in RED register four results (ri*N_INV) mod Q, each < Q, then go to OUT.
REQ-018 SHALL handle inputs >= Q (up to 2^30-1) with the same exact mod-Q result.
REQ-019 SHALL assert out_valid exactly in OUT; first out_valid 3 cycles after the accept edge.
REQ-020 SHALL present results in order r1, r2, r3, r4 via a 2-bit select; select advances only on handshake.
REQ-021 SHALL hold out_data, out_index and out_last stable while out_valid && !out_ready.
REQ-022 SHALL return to IDLE on the cycle after the 4th handshake; in_ready rises then.
REQ-023 SHALL increment out_index by 1 per handshake, wrapping 2^LOG_N-1 -> 0.
REQ-024 SHALL assert out_last iff out_valid && out_index == 2^LOG_N-1.
REQ-025 SHALL ignore in_valid outside IDLE; no input is stored or lost-counted.
REQ-026 SHALL, with out_ready held high, sustain one beat per 7 cycles: accept, MUL, RED, 4x OUT.

Reset
REQ-027 SHALL, while rst is high at a clock edge, force state IDLE, select 0, out_index 0.
REQ-028 SHALL drive out_valid 0, out_last 0 and out_data 0 during and after reset until new data.
REQ-029 SHALL have in_ready 0 while rst is asserted and 1 on the first cycle after release.
REQ-030 SHALL discard any in-flight beat on reset mid-operation; no partial output follows.
REQ-031 SHALL give rst priority over a simultaneous in_valid or out_ready handshake.

Verification
REQ-032 SHALL pass: r1..r4 = 1, 4096, 0, 8192, out_ready=1 -> out_data 998000641, 1, 0, 2; index 0..3; first valid 3 cycles after accept.
REQ-033 SHALL pass: r1 = 998244352 (Q-1), r2 = 1073741823 (2^30-1) -> out_data 243712, then (1073741823*N_INV) mod Q from a reference model.
REQ-034 SHALL pass: out_ready low 5 cycles on 2nd coefficient -> out_data/out_index frozen, in_ready stays 0, no skip or repeat.
REQ-035 SHALL pass: 1024 back-to-back beats -> out_index 0..4095, out_last exactly once at 4095, next frame starts at 0.
REQ-036 SHALL pass: rst pulsed for 1 cycle during OUT at select 2 -> out_valid 0 next cycle, out_index 0, in_ready 1 after release.
REQ-037 SHALL pass: in_valid held high during MUL/RED/OUT with changing r1..r4 -> only the IDLE-cycle values appear at output.
